// File: rtl/aes_round_ctrl_if.sv
// aes_round_ctrl_if
//   Handshake bundle between the AES round controller and its requester /
//   datapath. clk and rst are not part of the bundle.
//
//   Requester -> controller : start, key_len[1:0], decrypt, step_done
//   Controller -> requester : busy, done, err, en_SubBytes, en_ShiftRows,
//                             en_MixColumns, en_AddRoundKey, key_next, sel,
//                             inv, round_idx[3:0], RCON[7:0]
//
//   master : requester/datapath side (drives start, key_len, decrypt, step_done)
//   slave  : controller side
interface aes_round_ctrl_if;
    logic       start;
    logic [1:0] key_len;
    logic       decrypt;
    logic       step_done;
    logic       busy;
    logic       done;
    logic       err;
    logic       en_SubBytes;
    logic       en_ShiftRows;
    logic       en_MixColumns;
    logic       en_AddRoundKey;
    logic       key_next;
    logic       sel;
    logic       inv;
    logic [3:0] round_idx;
    logic [7:0] RCON;

    modport master (
        output start, key_len, decrypt, step_done,
        input  busy, done, err, en_SubBytes, en_ShiftRows, en_MixColumns,
               en_AddRoundKey, key_next, sel, inv, round_idx, RCON
    );

    modport slave (
        input  start, key_len, decrypt, step_done,
        output busy, done, err, en_SubBytes, en_ShiftRows, en_MixColumns,
               en_AddRoundKey, key_next, sel, inv, round_idx, RCON
    );
endinterface

// File: rtl/aes_round_ctrl.sv
// aes_round_ctrl
//   Round sequencer for an AES datapath supporting AES-128/192/256. Every
//   step (SubBytes, ShiftRows, MixColumns, AddRoundKey) is held until the
//   datapath acknowledges it with step_done, so multi-cycle S-box and key
//   schedule implementations can be attached.
//
//   Parameters:
//     STEP_TIMEOUT : max cycles a step may wait for step_done before err is
//                    pulsed and the operation aborted; 0 disables it.
//   Optional feature:
//     AES_DECRYPT_EN : when defined, decrypt=1 runs the inverse cipher order
//                      and inv follows the latched decrypt; otherwise inv=0.
//   Ports:
//     clk  : clock, rising edge
//     rst  : synchronous active-high reset
//     bus  : aes_round_ctrl_if.slave (start/key_len/decrypt/step_done in;
//            busy/done/err/step enables/key_next/sel/inv/round_idx/RCON out)
module aes_round_ctrl #(
    parameter int unsigned STEP_TIMEOUT = 0
) (
    input  logic           clk,
    input  logic           rst,
    aes_round_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT_ARK,
        S_SUB,
        S_SHIFT,
        S_MIX,
        S_ARK,
        S_DONE
    } state_t;

`ifdef AES_DECRYPT_EN
    localparam logic DEC_EN = 1'b1;
`else
    localparam logic DEC_EN = 1'b0;
`endif

    // Counter holds 0..STEP_TIMEOUT-1; expiry is detected on its last value.
    localparam int unsigned WW = (STEP_TIMEOUT > 1) ? $clog2(STEP_TIMEOUT) : 1;

    state_t        state_q, state_d;
    logic [3:0]    round_q, round_d;
    logic [3:0]    nr_q, nr_d;
    logic          inv_q, inv_d;
    logic [WW-1:0] wait_q, wait_d;
    logic          err_d;
    logic          key_next;
    logic          last_rnd;
    logic          step_st;

    logic busy_q, done_q, err_q, sel_q;
    logic en_sub_q, en_shift_q, en_mix_q, en_ark_q;
    logic [7:0] rcon;

    always_comb begin
        state_d  = state_q;
        round_d  = round_q;
        nr_d     = nr_q;
        inv_d    = inv_q;
        wait_d   = '0;
        err_d    = 1'b0;
        key_next = 1'b0;
        last_rnd = inv_q ? (round_q == 4'd0) : (round_q == nr_q);
        step_st  = state_q inside {S_INIT_ARK, S_SUB, S_SHIFT, S_MIX, S_ARK};

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    case (bus.key_len)
                        2'b01:   nr_d = 4'd12;
                        2'b10:   nr_d = 4'd14;
                        default: nr_d = 4'd10;
                    endcase
                    inv_d   = bus.decrypt & DEC_EN;
                    round_d = inv_d ? nr_d : 4'd0;
                    state_d = S_INIT_ARK;
                end
            end
            S_INIT_ARK: begin
                if (bus.step_done) begin
                    key_next = 1'b1;
                    round_d  = inv_q ? round_q - 4'd1 : round_q + 4'd1;
                    state_d  = inv_q ? S_SHIFT : S_SUB;
                end
            end
            S_SUB: begin
                if (bus.step_done) state_d = inv_q ? S_ARK : S_SHIFT;
            end
            S_SHIFT: begin
                if (bus.step_done) state_d = inv_q ? S_SUB : (last_rnd ? S_ARK : S_MIX);
            end
            S_MIX: begin
                if (bus.step_done) state_d = inv_q ? S_SHIFT : S_ARK;
            end
            S_ARK: begin
                if (bus.step_done) begin
                    if (last_rnd) begin
                        state_d = S_DONE;
                    end else begin
                        // Inverse cipher: ARK precedes MIX, so the round index
                        // already points at the next round during InvMixColumns.
                        key_next = 1'b1;
                        round_d  = inv_q ? round_q - 4'd1 : round_q + 4'd1;
                        state_d  = inv_q ? S_MIX : S_SUB;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // A step state only persists while step_done is low, so counting
        // there and clearing otherwise clears on every state change.
        if (STEP_TIMEOUT != 0 && step_st && !bus.step_done) begin
            if (wait_q == WW'(STEP_TIMEOUT - 1)) begin
                err_d   = 1'b1;
                state_d = S_IDLE;
            end else begin
                wait_d = wait_q + 1'b1;
            end
        end
    end

    // Outputs are decoded from the next state and registered, so they line up
    // with state_q and never depend combinationally on step_done.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            round_q    <= '0;
            nr_q       <= '0;
            inv_q      <= 1'b0;
            wait_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            sel_q      <= 1'b0;
            en_sub_q   <= 1'b0;
            en_shift_q <= 1'b0;
            en_mix_q   <= 1'b0;
            en_ark_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            round_q    <= round_d;
            nr_q       <= nr_d;
            inv_q      <= inv_d;
            wait_q     <= wait_d;
            busy_q     <= state_d inside {S_INIT_ARK, S_SUB, S_SHIFT, S_MIX, S_ARK};
            done_q     <= (state_d == S_DONE);
            err_q      <= err_d;
            sel_q      <= state_d inside {S_SUB, S_SHIFT, S_MIX, S_ARK, S_DONE};
            en_sub_q   <= (state_d == S_SUB);
            en_shift_q <= (state_d == S_SHIFT);
            en_mix_q   <= (state_d == S_MIX);
            en_ark_q   <= (state_d == S_INIT_ARK) || (state_d == S_ARK);
        end
    end

    always_comb begin
        case (round_q)
            4'd1:    rcon = 8'h01;
            4'd2:    rcon = 8'h02;
            4'd3:    rcon = 8'h04;
            4'd4:    rcon = 8'h08;
            4'd5:    rcon = 8'h10;
            4'd6:    rcon = 8'h20;
            4'd7:    rcon = 8'h40;
            4'd8:    rcon = 8'h80;
            4'd9:    rcon = 8'h1B;
            4'd10:   rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    end

    assign bus.busy           = busy_q;
    assign bus.done           = done_q;
    assign bus.err            = err_q;
    assign bus.sel            = sel_q;
    assign bus.inv            = inv_q;
    assign bus.en_SubBytes    = en_sub_q;
    assign bus.en_ShiftRows   = en_shift_q;
    assign bus.en_MixColumns  = en_mix_q;
    assign bus.en_AddRoundKey = en_ark_q;
    assign bus.key_next       = key_next;
    assign bus.round_idx      = round_q;
    assign bus.RCON           = rcon;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// tb_aes_round_ctrl
//   Scoreboard bench for aes_round_ctrl (STEP_TIMEOUT=8). Each operation
//   pushes its expected step sequence; a negedge monitor pops one entry per
//   completed step, done pulse or err pulse and compares.
module tb_aes_round_ctrl;

    localparam int K_SUB = 0, K_SHIFT = 1, K_MIX = 2, K_ARK = 3,
                   K_INIT = 4, K_DONE = 5, K_ERR = 6;

`ifdef AES_DECRYPT_EN
    localparam bit DEC_EN = 1'b1;
`else
    localparam bit DEC_EN = 1'b0;
`endif

    typedef struct {
        int         kind;
        logic [3:0] rnd;
        logic       sel;
        logic       inv;
        logic       kn;
    } exp_t;

    exp_t exp_q[$];

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_assert = 0;
    int   n_fail   = 0;
    int   kn_cnt   = 0;
    int   mix_cnt  = 0;
    int   max_dly  = 0;
    bit   stuck_shift = 1'b0;

    aes_round_ctrl_if bus();

    aes_round_ctrl #(.STEP_TIMEOUT(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic any_en;
    assign any_en = bus.en_SubBytes | bus.en_ShiftRows | bus.en_MixColumns | bus.en_AddRoundKey;

    function automatic logic [7:0] rcon_ref(input logic [3:0] r);
        case (r)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1B;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int kind, input int rnd, input bit sel, input bit inv, input bit kn);
        exp_t e;
        logic [31:0] r;
        r     = rnd;
        e.kind = kind;
        e.rnd  = r[3:0];
        e.sel  = sel;
        e.inv  = inv;
        e.kn   = kn;
        exp_q.push_back(e);
    endtask

    function automatic int nr_of(input logic [1:0] kl);
        return (kl == 2'b01) ? 12 : (kl == 2'b10) ? 14 : 10;
    endfunction

    task automatic expect_op(input logic [1:0] kl, input bit dec);
        int nr;
        bit d;
        nr = nr_of(kl);
        d  = dec && DEC_EN;
        if (!d) begin
            push(K_INIT, 0, 0, 0, 1);
            for (int r = 1; r <= nr; r++) begin
                push(K_SUB, r, 1, 0, 0);
                push(K_SHIFT, r, 1, 0, 0);
                if (r < nr) push(K_MIX, r, 1, 0, 0);
                push(K_ARK, r, 1, 0, r < nr);
            end
            push(K_DONE, nr, 1, 0, 0);
        end else begin
            push(K_INIT, nr, 0, 1, 1);
            for (int r = nr - 1; r >= 0; r--) begin
                push(K_SHIFT, r, 1, 1, 0);
                push(K_SUB, r, 1, 1, 0);
                push(K_ARK, r, 1, 1, r > 0);
                if (r > 0) push(K_MIX, r - 1, 1, 1, 0);
            end
            push(K_DONE, 0, 1, 1, 0);
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_busy"}, bus.busy, 0);
        check({tag, "_done"}, bus.done, 0);
        check({tag, "_err"}, bus.err, 0);
        check({tag, "_enables"}, {bus.en_SubBytes, bus.en_ShiftRows, bus.en_MixColumns, bus.en_AddRoundKey}, 0);
        check({tag, "_key_next"}, bus.key_next, 0);
        check({tag, "_sel"}, bus.sel, 0);
        check({tag, "_inv"}, bus.inv, 0);
        check({tag, "_round_idx"}, bus.round_idx, 0);
        check({tag, "_RCON"}, bus.RCON, 0);
    endtask

    // exp_cyc = 0 skips the latency check; poke_start raises start mid-run.
    task automatic run_op(input logic [1:0] kl, input bit dec, input int exp_cyc, input bit poke_start);
        int cyc;
        int nr;
        nr = nr_of(kl);
        expect_op(kl, dec);
        check("idle_before_start", bus.busy, 0);
        bus.key_len = kl;
        bus.decrypt = dec;
        bus.start   = 1'b1;
        tick();
        bus.start   = 1'b0;
        check("busy_after_accept", bus.busy, 1);
        cyc = 1;
        while (!bus.done && cyc < 2000) begin
            bus.start = (poke_start && cyc == 20);
            tick();
            cyc++;
        end
        bus.start = 1'b0;
        check("done_seen", bus.done, 1);
        if (exp_cyc != 0) check("accept_to_done_cycles", cyc, exp_cyc);
        tick();
        check("idle_after_done", bus.busy, 0);
        check("done_one_cycle", bus.done, 0);
        check("round_idx_hold", bus.round_idx, (dec && DEC_EN) ? 0 : nr);
        check("sb_drained", exp_q.size(), 0);
    endtask

    // Datapath responder: acknowledges steps immediately, after a random
    // delay, or never while in ShiftRows.
    initial begin : responder
        int cnt;
        int dly;
        cnt = 0;
        dly = 0;
        bus.step_done = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (stuck_shift && bus.en_ShiftRows) begin
                bus.step_done = 1'b0;
            end else if (max_dly == 0) begin
                bus.step_done = 1'b1;
            end else if (any_en) begin
                if (cnt >= dly) begin
                    bus.step_done = 1'b1;
                    cnt = 0;
                    dly = $urandom_range(max_dly, 0);
                end else begin
                    bus.step_done = 1'b0;
                    cnt++;
                end
            end else begin
                bus.step_done = 1'b0;
            end
        end
    end

    logic [3:0] prev_en   = '0;
    logic       prev_sd   = 1'b0;
    logic       prev_busy = 1'b0;

    always @(negedge clk) begin : monitor
        logic [3:0] en;
        int   k;
        exp_t e;
        en = {bus.en_AddRoundKey, bus.en_MixColumns, bus.en_ShiftRows, bus.en_SubBytes};
        if (rst) begin
            prev_en   = '0;
            prev_sd   = 1'b0;
            prev_busy = 1'b0;
        end else begin
            if (bus.key_next) kn_cnt++;
            if (bus.en_MixColumns && !prev_en[2]) mix_cnt++;
            if (bus.busy) begin
                check("onehot_enable", $countones(en), 1);
                if (prev_busy && !prev_sd) check("enable_hold", en, prev_en);
                if (bus.step_done) begin
                    k = en[0] ? K_SUB : en[1] ? K_SHIFT : en[2] ? K_MIX :
                        en[3] ? (bus.sel ? K_ARK : K_INIT) : -1;
                    if (exp_q.size() == 0) begin
                        check("sb_unexpected_step", k, -1);
                    end else begin
                        e = exp_q.pop_front();
                        check("step_kind", k, e.kind);
                        check("step_round_idx", bus.round_idx, e.rnd);
                        check("step_sel", bus.sel, e.sel);
                        check("step_inv", bus.inv, e.inv);
                        check("step_key_next", bus.key_next, e.kn);
                        check("step_RCON", bus.RCON, rcon_ref(e.rnd));
                    end
                end else begin
                    check("key_next_while_waiting", bus.key_next, 0);
                end
            end
            if (bus.done) begin
                if (exp_q.size() == 0) begin
                    check("sb_unexpected_done", K_DONE, -1);
                end else begin
                    e = exp_q.pop_front();
                    check("done_kind", K_DONE, e.kind);
                    check("done_round_idx", bus.round_idx, e.rnd);
                    check("done_busy_low", bus.busy, 0);
                end
            end
            if (bus.err) begin
                if (exp_q.size() == 0) begin
                    check("sb_unexpected_err", K_ERR, -1);
                end else begin
                    e = exp_q.pop_front();
                    check("err_kind", K_ERR, e.kind);
                    check("err_no_done", bus.done, 0);
                end
            end
            prev_en   = en;
            prev_sd   = bus.step_done;
            prev_busy = bus.busy;
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int c;
        bus.start   = 1'b0;
        bus.key_len = 2'b00;
        bus.decrypt = 1'b0;

        rst = 1'b1;
        repeat (3) tick();
        check_quiet("reset");
        rst = 1'b0;
        tick();
        check_quiet("post_reset");

        // AES-128, one-cycle steps
        kn_cnt  = 0;
        mix_cnt = 0;
        run_op(2'b00, 1'b0, 41, 1'b0);
        check("aes128_key_next_count", kn_cnt, 10);
        check("aes128_mix_count", mix_cnt, 9);

        // AES-192 with an ignored start while busy, AES-256, key_len=11
        run_op(2'b01, 1'b0, 49, 1'b1);
        run_op(2'b10, 1'b0, 57, 1'b0);
        run_op(2'b11, 1'b0, 41, 1'b0);

        // Random step_done latency 0..5 cycles
        max_dly = 5;
        run_op(2'b00, 1'b0, 0, 1'b0);
        run_op(2'b10, 1'b0, 0, 1'b0);
        max_dly = 0;
        tick();

        // Reset in round 5
        expect_op(2'b00, 1'b0);
        bus.key_len = 2'b00;
        bus.start   = 1'b1;
        tick();
        bus.start = 1'b0;
        c = 0;
        while (bus.round_idx != 4'd5 && c < 200) begin
            tick();
            c++;
        end
        check("reached_round5", bus.round_idx, 5);
        rst = 1'b1;
        exp_q.delete();
        tick();
        check_quiet("mid_op_reset");
        rst = 1'b0;
        tick();
        run_op(2'b00, 1'b0, 41, 1'b0);

        // Step timeout in ShiftRows of round 1
        stuck_shift = 1'b1;
        push(K_INIT, 0, 0, 0, 1);
        push(K_SUB, 1, 1, 0, 0);
        push(K_ERR, 0, 0, 0, 0);
        bus.key_len = 2'b00;
        bus.start   = 1'b1;
        tick();
        bus.start = 1'b0;
        c = 0;
        while (!bus.en_ShiftRows && c < 20) begin
            tick();
            c++;
        end
        check("entered_shift", bus.en_ShiftRows, 1);
        c = 0;
        while (!bus.err && c < 50) begin
            tick();
            c++;
        end
        check("timeout_latency", c, 8);
        check("timeout_no_done", bus.done, 0);
        check("timeout_busy_low", bus.busy, 0);
        tick();
        check("timeout_err_one_cycle", bus.err, 0);
        check("timeout_idle", bus.busy, 0);
        check("timeout_sb_drained", exp_q.size(), 0);
        stuck_shift = 1'b0;
        tick();

        // Decrypt request (inverse order only when the feature is built in)
        run_op(2'b00, 1'b1, 41, 1'b0);
        bus.decrypt = 1'b0;
        repeat (3) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/aes_round_ctrl.md
# aes_round_ctrl

Parametrised round controller for the AES datapath, replacing the fixed AES-128 round FSM. It sequences SubBytes, ShiftRows, MixColumns and AddRoundKey for AES-128, AES-192 and AES-256, selected per operation. Each step waits on a completion handshake from the datapath, so multi-cycle S-box and key-schedule implementations are supported. It also drives the round index and RCON used by the key schedule, and the datapath input select.

## Interface
- `STEP_TIMEOUT`, default 0 – if non-zero, maximum cycles any step may wait for `step_done` before `err` is raised and the controller aborts; 0 disables the timeout.
- `clk` input 1 – clock; all logic on rising edge.
- `rst` input 1 – reset, synchronous, active-high.
- `start` input 1 – operation request; sampled only in IDLE.
- `key_len` input 2 – 00 = AES-128 (Nr=10), 01 = AES-192 (Nr=12), 10 = AES-256 (Nr=14), 11 = treated as 00; latched on accept.
- `decrypt` input 1 – inverse cipher request; latched on accept; only honoured under `AES_DECRYPT_EN`.
- `step_done` input 1 – datapath has completed the currently enabled step.
- `busy` output 1 – operation in progress.
- `done` output 1 – one-cycle completion pulse.
- `err` output 1 – one-cycle pulse when a step timeout aborts the operation.
- `en_SubBytes`, `en_ShiftRows`, `en_MixColumns`, `en_AddRoundKey` output 1 each – step enables. These are the inverse transforms when `inv`=1.
- `key_next` output 1 – one-cycle pulse telling the key schedule to advance to the next round key.
- `sel` output 1 – 0 selects the external state input, 1 selects the round-state register.
- `inv` output 1 – latched `decrypt`; constant 0 without `AES_DECRYPT_EN`.
- `round_idx` output 4 – current round number, 0..Nr.
- `RCON` output 8 – round constant for `round_idx`.

## Operation
- States: IDLE, INIT_ARK, SUB, SHIFT, MIX, ARK, DONE.
- **IDLE**
  - All enables, `busy`, `done`, `err` and `key_next` are 0.
  - `start`=1 latches `key_len` and `decrypt`, loads `round_idx` (0 for encrypt, Nr for decrypt), and moves to INIT_ARK.
- **Step states**
  - Exactly one enable is high: its own. `busy`=1.
  - The state holds until `step_done`=1 in that state; `step_done` in IDLE or DONE is ignored.
- **Encrypt order**
  - INIT_ARK (`sel`=0) -> SUB -> SHIFT -> MIX -> ARK, repeated for rounds 1..Nr-1.
  - Final round Nr: SUB -> SHIFT -> ARK, with no MIX.
  - `sel`=1 in every state after INIT_ARK.
- **Round advance**
  - Completing INIT_ARK or ARK pulses `key_next` and increments `round_idx` (decrements when decrypting).
  - Completing the ARK of the final round goes to DONE instead.
- **DONE**
  - `done`=1 and `busy`=0 for one cycle, then IDLE.
  - `round_idx` holds its final value until the next accept.
- **RCON** is combinational on `round_idx`:
  - 1->01, 2->02, 3->04, 4->08, 5->10, 6->20, 7->40, 8->80, 9->1B, 10->36.
  - All other values -> 00.
  - Round-to-RCON mapping for AES-192/256 is the key schedule's responsibility.
- **Timeout** (only when `STEP_TIMEOUT` != 0)
  - A wait counter clears on every state change.
  - Reaching `STEP_TIMEOUT` pulses `err` and returns to IDLE; `done` is not pulsed.
- `start` while busy is ignored; it is not queued.

## Timing
- Reset values: state IDLE, every output 0, `round_idx`=0, internal counters 0.
- Reset asserted mid-operation returns to IDLE on the next edge with no `done` pulse.
- `busy` rises in the first cycle after the accepting edge.
- Enables are registered-state decodes (Moore); no combinational path from `step_done` to any enable.
- With `step_done` tied to 1, each step lasts 1 cycle. Cycles from accept to the `done` cycle:
  - AES-128: 40 step cycles plus the `done` cycle.
  - AES-192: 48 step cycles plus the `done` cycle.
  - AES-256: 56 step cycles plus the `done` cycle.
- `key_next` is coincident with the cycle that `step_done` completes the ARK step.
- A new `start` may be accepted in the cycle after `done`, since the controller is then in IDLE.

## Configuration
- `AES_DECRYPT_EN` defined:
  - `decrypt`=1 runs the inverse order.
  - INIT_ARK, then for rounds Nr-1 down to 1: SHIFT (inverse) -> SUB (inverse) -> ARK -> MIX (inverse).
  - Final round (round 0): SHIFT -> SUB -> ARK.
  - `round_idx` counts down; `inv`=1 throughout the operation.
- `AES_DECRYPT_EN` undefined: `decrypt` is ignored, `inv` is tied to 0, and only encrypt order exists.

## Test plan
- Reset, then `start` with `key_len`=00 and `step_done`=1 -> 40 step cycles, then `done` pulse. `key_next` pulses 10 times; MIX is entered 9 times; `RCON` sequence is 01..36.
- `key_len`=01, then 10, with `step_done`=1 -> `done` after 48 / 56 step cycles; `round_idx` ends at 12 / 14; `key_len`=11 behaves as AES-128.
- `step_done` delayed randomly 0–5 cycles -> each enable holds until `step_done`; step order is unchanged.
- Reset asserted during round 5 -> IDLE on the next edge with all outputs 0; a following `start` completes normally.
- `STEP_TIMEOUT`=8 with `step_done` stuck low in SHIFT -> `err` pulses 8 cycles after entering SHIFT, then IDLE with no `done`.
- With `AES_DECRYPT_EN`, `decrypt`=1, `key_len`=00 -> `round_idx` runs 10 down to 0; `inv`=1; first round after INIT_ARK is SHIFT, SUB, ARK, MIX; `done` after 40 step cycles.
